// File: rtl/core_id_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_id_scoreboard_pkg
// Brief    : Shared widths and helpers for the decode-stage write scoreboard.
// Revision : 1.0
// ============================================================================
package core_id_scoreboard_pkg;

    localparam int CORE_RFIDX_WIDTH  = 5;
    localparam int CORE_SB_CNT_WIDTH = 2;

    // x0 is hardwired, so writes to it are never tracked.
    function automatic logic idx_tracked(input logic [CORE_RFIDX_WIDTH-1:0] idx);
        return idx != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_id_sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : core_id_sb_entry
// Brief    : Outstanding-write counter and youngest-is-load flag for one register.
// Revision : 1.0
// ============================================================================
module core_id_sb_entry
    import core_id_scoreboard_pkg::*;
#(
    parameter int CNT_W = CORE_SB_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_clr,
    input  logic i_ld,
    output logic o_busy,
    output logic o_multi,
    output logic o_full,
    output logic o_ld,
    output logic o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ld  <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ld  <= 1'b0;
        end else if (i_inc && i_dec) begin
            r_ld <= i_ld;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_ld  <= i_ld;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_ld <= 1'b0;
            end
        end
    end

    assign o_busy      = (r_cnt != '0);
    assign o_multi     = (r_cnt > CNT_W'(1));
    assign o_full      = (r_cnt == {CNT_W{1'b1}});
    assign o_ld        = r_ld;
    assign o_underflow = i_dec && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/core_id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : core_id_scoreboard
// Brief    : Per-register outstanding-write scoreboard driving decode stall/empty.
// Revision : 1.0
// ============================================================================
module core_id_scoreboard
    import core_id_scoreboard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = CORE_SB_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_rs1_ren,
    input  logic                        i_rs2_ren,
    input  logic [CORE_RFIDX_WIDTH-1:0] i_rs1_idx,
    input  logic [CORE_RFIDX_WIDTH-1:0] i_rs2_idx,
    input  logic                        i_rd_wen,
    input  logic [CORE_RFIDX_WIDTH-1:0] i_rd_idx,
    input  logic                        i_is_load,
    input  logic                        i_issue,
    input  logic                        i_ret_valid,
    input  logic                        i_ret_rd_wen,
    input  logic [CORE_RFIDX_WIDTH-1:0] i_ret_rd_idx,
    input  logic                        i_flush_all,
    output logic                        o_rs1_busy,
    output logic                        o_rs2_busy,
    output logic                        o_stall,
    output logic                        o_empty,
    output logic                        o_err
);

    logic [NREG-1:0] w_nz;
    logic [NREG-1:0] w_multi;
    logic [NREG-1:0] w_full;
    logic [NREG-1:0] w_ld;
    logic [NREG-1:0] w_uf;

    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_stall;
    logic w_viol;
    logic w_iss_ev;
    logic w_ret_ev;
    logic r_err;

    assign w_nz[0]    = 1'b0;
    assign w_multi[0] = 1'b0;
    assign w_full[0]  = 1'b0;
    assign w_ld[0]    = 1'b0;
    assign w_uf[0]    = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        core_id_sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_iss_ev && (i_rd_idx == CORE_RFIDX_WIDTH'(r))),
            .i_dec       (w_ret_ev && (i_ret_rd_idx == CORE_RFIDX_WIDTH'(r))),
            .i_clr       (i_flush_all),
            .i_ld        (i_is_load),
            .o_busy      (w_nz[r]),
            .o_multi     (w_multi[r]),
            .o_full      (w_full[r]),
            .o_ld        (w_ld[r]),
            .o_underflow (w_uf[r])
        );
    end

    assign w_rs1_busy = i_rs1_ren && idx_tracked(i_rs1_idx) && w_nz[i_rs1_idx];
    assign w_rs2_busy = i_rs2_ren && idx_tracked(i_rs2_idx) && w_nz[i_rs2_idx];

    // Loads cannot be forwarded from EX, and only the youngest write sits in
    // the single EX forward path, so either case must hold decode.
    assign w_stall = (w_rs1_busy && (w_ld[i_rs1_idx] || w_multi[i_rs1_idx]))
                  || (w_rs2_busy && (w_ld[i_rs2_idx] || w_multi[i_rs2_idx]))
                  || (i_rd_wen && idx_tracked(i_rd_idx) && w_full[i_rd_idx]);

    // An issue against a stall freezes every counter for that cycle.
    assign w_viol   = i_issue && w_stall;
    assign w_iss_ev = i_issue && !w_stall && i_rd_wen && idx_tracked(i_rd_idx);
    assign w_ret_ev = i_ret_valid && !w_viol && i_ret_rd_wen && idx_tracked(i_ret_rd_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_viol || (|w_uf)) begin
            r_err <= 1'b1;
        end
    end

    assign o_rs1_busy = w_rs1_busy;
    assign o_rs2_busy = w_rs2_busy;
    assign o_stall    = w_stall;
    assign o_empty    = ~(|w_nz);
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core_id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_id_scoreboard
// Brief    : Vector table, directed corner cases and random model for the scoreboard.
// Revision : 1.0
// ============================================================================
module tb_core_id_scoreboard;

    localparam int MAXC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs1_ren, rs2_ren, rd_wen, is_load, issue, ret_valid, ret_rd_wen, flush_all;
    logic [4:0] rs1_idx, rs2_idx, rd_idx, ret_rd_idx;
    logic       rs1_busy, rs2_busy, stall, empty, err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int r1en, r1, r2en, r2, wen, rd, ld, iss, rv, rw, ri, fl;
        int eb1, eb2, est, eem, eer;
    } vec_t;

    vec_t vecs[25];

    int m_cnt[32];
    bit m_ld[32];
    bit m_err;
    int inflight[$];

    core_id_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .i_rs1_ren    (rs1_ren),
        .i_rs2_ren    (rs2_ren),
        .i_rs1_idx    (rs1_idx),
        .i_rs2_idx    (rs2_idx),
        .i_rd_wen     (rd_wen),
        .i_rd_idx     (rd_idx),
        .i_is_load    (is_load),
        .i_issue      (issue),
        .i_ret_valid  (ret_valid),
        .i_ret_rd_wen (ret_rd_wen),
        .i_ret_rd_idx (ret_rd_idx),
        .i_flush_all  (flush_all),
        .o_rs1_busy   (rs1_busy),
        .o_rs2_busy   (rs2_busy),
        .o_stall      (stall),
        .o_empty      (empty),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_ren    = 1'(v.r1en);
        rs1_idx    = 5'(v.r1);
        rs2_ren    = 1'(v.r2en);
        rs2_idx    = 5'(v.r2);
        rd_wen     = 1'(v.wen);
        rd_idx     = 5'(v.rd);
        is_load    = 1'(v.ld);
        issue      = 1'(v.iss);
        ret_valid  = 1'(v.rv);
        ret_rd_wen = 1'(v.rw);
        ret_rd_idx = 5'(v.ri);
        flush_all  = 1'(v.fl);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then cross the edge.
    task automatic apply(input vec_t v, input string tag);
        drive(v);
        #2;
        chk({tag, ".rs1_busy"}, rs1_busy, 1'(v.eb1));
        chk({tag, ".rs2_busy"}, rs2_busy, 1'(v.eb2));
        chk({tag, ".stall"},    stall,    1'(v.est));
        chk({tag, ".empty"},    empty,    1'(v.eem));
        chk({tag, ".err"},      err,      1'(v.eer));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0};
        return v;
    endfunction

    function automatic bit m_busy(input int en, input int idx);
        return (en != 0) && (idx != 0) && (m_cnt[idx] > 0);
    endfunction

    function automatic bit m_stall(input vec_t v);
        bit s;
        s = 1'b0;
        if (m_busy(v.r1en, v.r1) && (m_ld[v.r1] || m_cnt[v.r1] >= 2)) s = 1'b1;
        if (m_busy(v.r2en, v.r2) && (m_ld[v.r2] || m_cnt[v.r2] >= 2)) s = 1'b1;
        if (v.wen != 0 && v.rd != 0 && m_cnt[v.rd] == MAXC) s = 1'b1;
        return s;
    endfunction

    function automatic bit m_empty();
        for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_update(input vec_t v);
        bit viol, iss_ok, ret_ok;
        viol   = (v.iss != 0) && m_stall(v);
        iss_ok = !viol && v.iss != 0 && v.wen != 0 && v.rd != 0;
        ret_ok = !viol && v.rv != 0 && v.rw != 0 && v.ri != 0;
        if (viol) m_err = 1'b1;
        if (ret_ok && m_cnt[v.ri] == 0) m_err = 1'b1;
        if (v.fl != 0) begin
            for (int i = 0; i < 32; i++) begin
                m_cnt[i] = 0;
                m_ld[i]  = 1'b0;
            end
            inflight.delete();
        end else begin
            if (iss_ok && ret_ok && v.rd == v.ri) begin
                m_ld[v.rd] = v.ld != 0;
            end else begin
                if (iss_ok) begin
                    m_cnt[v.rd]++;
                    m_ld[v.rd] = v.ld != 0;
                end
                if (ret_ok && m_cnt[v.ri] > 0) begin
                    m_cnt[v.ri]--;
                    if (m_cnt[v.ri] == 0) m_ld[v.ri] = 1'b0;
                end
            end
            if (ret_ok) begin
                for (int k = 0; k < inflight.size(); k++) begin
                    if (inflight[k] == v.ri) begin
                        inflight.delete(k);
                        break;
                    end
                end
            end
            if (iss_ok) inflight.push_back(v.rd);
        end
    endtask

    initial begin
        vec_t v;

        //            r1en r1 r2en r2 wen rd ld iss rv rw ri fl  eb1 eb2 est eem eer
        vecs[0]  = '{0,0, 0,0,  1,5,0,1,   0,0,0,0,   0,0,0,1,0};
        vecs[1]  = '{1,5, 0,0,  0,0,0,0,   0,0,0,0,   1,0,0,0,0};
        vecs[2]  = '{1,5, 0,0,  0,0,0,0,   0,0,0,0,   1,0,0,0,0};
        vecs[3]  = '{1,5, 0,0,  0,0,0,0,   1,1,5,0,   1,0,0,0,0};
        vecs[4]  = '{1,5, 0,0,  0,0,0,0,   0,0,0,0,   0,0,0,1,0};
        vecs[5]  = '{0,0, 0,0,  1,7,1,1,   0,0,0,0,   0,0,0,1,0};
        vecs[6]  = '{0,0, 1,7,  0,0,0,0,   0,0,0,0,   0,1,1,0,0};
        vecs[7]  = '{0,0, 1,7,  0,0,0,0,   1,1,7,0,   0,1,1,0,0};
        vecs[8]  = '{0,0, 1,7,  0,0,0,0,   0,0,0,0,   0,0,0,1,0};
        vecs[9]  = '{0,0, 0,0,  1,3,0,1,   0,0,0,0,   0,0,0,1,0};
        vecs[10] = '{0,0, 0,0,  1,3,0,1,   0,0,0,0,   0,0,0,0,0};
        vecs[11] = '{0,0, 0,0,  1,3,0,1,   0,0,0,0,   0,0,0,0,0};
        vecs[12] = '{1,3, 0,0,  0,0,0,0,   0,0,0,0,   1,0,1,0,0};
        vecs[13] = '{0,0, 0,0,  1,3,0,0,   0,0,0,0,   0,0,1,0,0};
        vecs[14] = '{0,0, 0,0,  1,4,0,1,   0,0,0,0,   0,0,0,0,0};
        vecs[15] = '{0,0, 0,0,  1,9,1,1,   0,0,0,0,   0,0,0,0,0};
        vecs[16] = '{0,0, 0,0,  1,10,0,1,  0,0,0,1,   0,0,0,0,0};
        vecs[17] = '{1,10,1,4,  0,0,0,0,   0,0,0,0,   0,0,0,1,0};
        vecs[18] = '{0,0, 0,0,  1,0,0,1,   1,1,0,0,   0,0,0,1,0};
        vecs[19] = '{1,0, 0,0,  0,0,0,0,   0,0,0,0,   0,0,0,1,0};
        vecs[20] = '{0,0, 0,0,  0,0,0,0,   1,1,12,0,  0,0,0,1,0};
        vecs[21] = '{0,0, 0,0,  0,0,0,0,   0,0,0,0,   0,0,0,1,1};
        vecs[22] = '{0,0, 0,0,  1,6,0,1,   0,0,0,0,   0,0,0,1,1};
        vecs[23] = '{0,0, 0,0,  0,0,0,0,   0,0,0,1,   0,0,0,0,1};
        vecs[24] = '{1,6, 0,0,  0,0,0,0,   0,0,0,0,   0,0,0,1,1};

        drive(idle());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        v = idle();
        v.r1en = 1; v.r1 = 5;
        apply(v, "reset");

        for (int i = 0; i < 25; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Error must survive flush and clear only on reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(idle(), "post_reset");

        // Full counter: a retire+issue on the same register while stalled changes nothing.
        v = idle(); v.wen = 1; v.rd = 3; v.iss = 1;
        apply(v, "waw_iss1");
        v.eem = 0;
        apply(v, "waw_iss2");
        apply(v, "waw_iss3");
        v = idle(); v.eem = 0; v.r1en = 1; v.r1 = 3; v.wen = 1; v.rd = 3; v.iss = 1;
        v.rv = 1; v.rw = 1; v.ri = 3; v.eb1 = 1; v.est = 1;
        apply(v, "waw_viol");
        v = idle(); v.eem = 0; v.r1en = 1; v.r1 = 3; v.wen = 1; v.rd = 3;
        v.eb1 = 1; v.est = 1; v.eer = 1;
        apply(v, "waw_still_full");

        // Asynchronous reset mid-cycle drops tracking and error at once.
        drive(idle());
        #1;
        chk("async_pre.empty", empty, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst.empty", empty, 1'b1);
        chk("async_rst.err", err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_ld[i]  = 1'b0;
        end
        m_err = 1'b0;
        inflight.delete();

        for (int c = 0; c < 800; c++) begin
            int k;
            v = idle();
            v.r1en = int'($urandom_range(0, 1));
            v.r1   = int'($urandom_range(0, 7));
            v.r2en = int'($urandom_range(0, 1));
            v.r2   = int'($urandom_range(0, 7));
            v.wen  = int'($urandom_range(0, 3) != 0);
            v.rd   = int'($urandom_range(0, 7));
            v.ld   = int'($urandom_range(0, 2) == 0);
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, inflight.size() - 1));
                v.rv = 1; v.rw = 1; v.ri = inflight[k];
            end else if ($urandom_range(0, 40) == 0) begin
                v.rv = 1; v.rw = int'($urandom_range(0, 1)); v.ri = int'($urandom_range(0, 7));
            end
            v.fl = int'($urandom_range(0, 60) == 0);
            if (m_stall(v)) v.iss = int'($urandom_range(0, 30) == 0);
            else            v.iss = int'($urandom_range(0, 1));
            v.eb1 = int'(m_busy(v.r1en, v.r1));
            v.eb2 = int'(m_busy(v.r2en, v.r2));
            v.est = int'(m_stall(v));
            v.eem = int'(m_empty());
            v.eer = int'(m_err);
            apply(v, "rnd");
            m_update(v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
